bridge_datatable_ram: RTL and testbench

// - Dual-port 1024x32 data-table RAM shared between the core (port A) and the host bridge (port B).
// - Contains a SYNC_STAGES-deep synchronizer for the asynchronous bridge endianness flag.
// - The synchronized flag byte-swaps port B write data and read data.
// - Sits inside the bridge command handler, which maps the table at bridge offset 0x2000.

---
 rtl/bridge_datatable_ram_if.sv | 26 ++
 rtl/bridge_datatable_ram.sv | 62 ++++++
 tb/tb_bridge_datatable_ram.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/bridge_datatable_ram_if.sv
// rtl/bridge_datatable_ram_if.sv - core/bridge port bundle for the data-table RAM
interface bridge_datatable_ram_if #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32
);
    logic                  endian_little_async;
    logic                  endian_little_s;
    logic [ADDR_WIDTH-1:0] a_addr;
    logic                  a_wren;
    logic [DATA_WIDTH-1:0] a_data;
    logic [DATA_WIDTH-1:0] a_q;
    logic [ADDR_WIDTH-1:0] b_addr;
    logic                  b_wren;
    logic [DATA_WIDTH-1:0] b_data;
    logic [DATA_WIDTH-1:0] b_q;

    modport master (
        output endian_little_async, a_addr, a_wren, a_data, b_addr, b_wren, b_data,
        input  endian_little_s, a_q, b_q
    );

    modport slave (
        input  endian_little_async, a_addr, a_wren, a_data, b_addr, b_wren, b_data,
        output endian_little_s, a_q, b_q
    );
endinterface

// File: rtl/bridge_datatable_ram.sv
// rtl/bridge_datatable_ram.sv - dual-port data-table RAM with byte-swapped bridge port
module bridge_datatable_ram #(
    parameter int ADDR_WIDTH  = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int SYNC_STAGES = 3
) (
    input  logic clk,
    input  logic reset_n,
    bridge_datatable_ram_if.slave bus
);
    localparam int DEPTH     = 1 << ADDR_WIDTH;
    localparam int NUM_BYTES = DATA_WIDTH / 8;

    function automatic logic [DATA_WIDTH-1:0] byte_swap(input logic [DATA_WIDTH-1:0] d);
        logic [DATA_WIDTH-1:0] r;
        r = '0;
        for (int i = 0; i < NUM_BYTES; i++) begin
            r[8*i +: 8] = d[DATA_WIDTH-8-8*i +: 8];
        end
        return r;
    endfunction

    logic [DATA_WIDTH-1:0]  mem [DEPTH];
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [DATA_WIDTH-1:0]  a_rd_q, a_rd_d;
    logic [DATA_WIDTH-1:0]  b_rd_q, b_rd_d;
    logic                   endian_s;
    logic [DATA_WIDTH-1:0]  b_wr_word;

    assign endian_s = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], bus.endian_little_async};
        a_rd_d    = mem[bus.a_addr];
        b_rd_d    = mem[bus.b_addr];
        b_wr_word = endian_s ? byte_swap(bus.b_data) : bus.b_data;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            a_rd_q <= '0;
            b_rd_q <= '0;
        end else begin
            sync_q <= sync_d;
            a_rd_q <= a_rd_d;
            b_rd_q <= b_rd_d;
        end
    end

    // Port A is written last so it wins a same-address collision.
    always_ff @(posedge clk) begin
        if (reset_n) begin
            if (bus.b_wren) mem[bus.b_addr] <= b_wr_word;
            if (bus.a_wren) mem[bus.a_addr] <= bus.a_data;
        end
    end

    assign bus.endian_little_s = endian_s;
    assign bus.a_q             = a_rd_q;
    assign bus.b_q             = endian_s ? byte_swap(b_rd_q) : b_rd_q;
endmodule

// File: tb/tb_bridge_datatable_ram.sv
// tb/tb_bridge_datatable_ram.sv - directed self-checking bench for bridge_datatable_ram
module tb_bridge_datatable_ram;
    logic clk = 1'b0;
    logic reset_n;
    int   n_vec = 0;
    int   n_err = 0;

    bridge_datatable_ram_if #(.ADDR_WIDTH(10), .DATA_WIDTH(32)) bif ();

    bridge_datatable_ram #(.ADDR_WIDTH(10), .DATA_WIDTH(32), .SYNC_STAGES(3)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        bif.endian_little_async = 1'b0;
        bif.a_addr = '0; bif.a_wren = 1'b0; bif.a_data = '0;
        bif.b_addr = '0; bif.b_wren = 1'b0; bif.b_data = '0;
        step();
        n_vec++;
        if (bif.endian_little_s !== 1'b0 || bif.a_q !== 32'h0 || bif.b_q !== 32'h0) begin
            n_err++;
            $display("FAIL reset_init: s=%b a_q=%h b_q=%h want 0/0/0", bif.endian_little_s, bif.a_q, bif.b_q);
        end
        reset_n = 1'b1;
        bif.endian_little_async = 1'b1;
        bif.a_wren = 1'b1; bif.a_addr = 10'h001; bif.a_data = 32'h12345678;
        step();
        bif.a_wren = 1'b0;
        step();
        step();
        n_vec++;
        if (bif.a_q !== 32'h12345678 || bif.endian_little_s !== 1'b1) begin
            n_err++;
            $display("FAIL reset_preop: a_q=%h s=%b want 12345678/1", bif.a_q, bif.endian_little_s);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_vec++;
        if (bif.endian_little_s !== 1'b0 || bif.a_q !== 32'h0 || bif.b_q !== 32'h0) begin
            n_err++;
            $display("FAIL reset_async: s=%b a_q=%h b_q=%h want 0/0/0", bif.endian_little_s, bif.a_q, bif.b_q);
        end
        step();
        reset_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step();
            n_vec++;
            if (bif.endian_little_s !== (e == 3)) begin
                n_err++;
                $display("FAIL reset_sync_edge%0d: s=%b want %b", e, bif.endian_little_s, (e == 3));
            end
        end
    endtask

    task automatic test_port_a();
        bif.a_wren = 1'b1; bif.a_addr = 10'h005; bif.a_data = 32'h11223344;
        step();
        bif.a_wren = 1'b0;
        step();
        n_vec++;
        if (bif.a_q !== 32'h11223344) begin
            n_err++;
            $display("FAIL port_a_roundtrip: a_q=%h want 11223344", bif.a_q);
        end
    endtask

    task automatic test_cross_swap();
        bif.a_wren = 1'b1; bif.a_addr = 10'h3FF; bif.a_data = 32'h11223344;
        step();
        bif.a_wren = 1'b0; bif.b_addr = 10'h3FF;
        step();
        n_vec++;
        if (bif.b_q !== 32'h44332211) begin
            n_err++;
            $display("FAIL cross_a_to_b: b_q=%h want 44332211", bif.b_q);
        end
        bif.b_wren = 1'b1; bif.b_addr = 10'h000; bif.b_data = 32'hAABBCCDD;
        step();
        bif.b_wren = 1'b0; bif.a_addr = 10'h000;
        step();
        n_vec++;
        if (bif.a_q !== 32'hDDCCBBAA) begin
            n_err++;
            $display("FAIL cross_b_to_a: a_q=%h want DDCCBBAA", bif.a_q);
        end
        n_vec++;
        if (bif.b_q !== 32'hAABBCCDD) begin
            n_err++;
            $display("FAIL cross_b_to_b: b_q=%h want AABBCCDD", bif.b_q);
        end
    endtask

    task automatic test_collision();
        bif.a_wren = 1'b1; bif.a_addr = 10'h010; bif.a_data = 32'hA5A5A5A5;
        bif.b_wren = 1'b1; bif.b_addr = 10'h010; bif.b_data = 32'h5A5A5A5A;
        step();
        bif.a_wren = 1'b0; bif.b_wren = 1'b0;
        step();
        n_vec++;
        if (bif.a_q !== 32'hA5A5A5A5) begin
            n_err++;
            $display("FAIL collision_a_wins: a_q=%h want A5A5A5A5", bif.a_q);
        end
    endtask

    task automatic test_read_during_write();
        bif.endian_little_async = 1'b0;
        step(); step(); step();
        n_vec++;
        if (bif.endian_little_s !== 1'b0) begin
            n_err++;
            $display("FAIL rdw_endian_clear: s=%b want 0", bif.endian_little_s);
        end
        bif.a_wren = 1'b1; bif.a_addr = 10'h020; bif.a_data = 32'h0;
        step();
        bif.a_data = 32'hDEADBEEF; bif.b_addr = 10'h020;
        step();
        n_vec++;
        if (bif.b_q !== 32'h0 || bif.a_q !== 32'h0) begin
            n_err++;
            $display("FAIL rdw_old_word: a_q=%h b_q=%h want 0/0", bif.a_q, bif.b_q);
        end
        bif.a_wren = 1'b0;
        step();
        n_vec++;
        if (bif.b_q !== 32'hDEADBEEF || bif.a_q !== 32'hDEADBEEF) begin
            n_err++;
            $display("FAIL rdw_new_word: a_q=%h b_q=%h want DEADBEEF/DEADBEEF", bif.a_q, bif.b_q);
        end
    endtask

    task automatic test_endian_toggle();
        logic [31:0] want;
        bif.endian_little_async = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            step();
            want = (e == 3) ? 32'hEFBEADDE : 32'hDEADBEEF;
            n_vec++;
            if (bif.b_q !== want) begin
                n_err++;
                $display("FAIL endian_toggle_edge%0d: b_q=%h want %h", e, bif.b_q, want);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] wr   [4];
        logic [31:0] want [4];
        wr[0] = 32'h01020304; want[0] = 32'h04030201;
        wr[1] = 32'hCAFEF00D; want[1] = 32'h0DF0FECA;
        wr[2] = 32'h00000080; want[2] = 32'h80000000;
        wr[3] = 32'hFFFF0000; want[3] = 32'h0000FFFF;
        for (int i = 0; i < 4; i++) begin
            bif.b_wren = 1'b1; bif.b_addr = 10'h100 + 10'(i); bif.b_data = wr[i];
            step();
        end
        bif.b_wren = 1'b0;
        for (int i = 0; i < 4; i++) begin
            bif.a_addr = 10'h100 + 10'(i);
            step();
            n_vec++;
            if (bif.a_q !== want[i]) begin
                n_err++;
                $display("FAIL b2b_word%0d: a_q=%h want %h", i, bif.a_q, want[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_port_a();
        test_cross_swap();
        test_collision();
        test_read_during_write();
        test_endian_toggle();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
